// File: rtl/gas_util_pkg.sv
// Shared types for the gas-engine utility layer: shift-register operation
// select used by serial blocks.
package gas_util_pkg;

   localparam int SHIFT_MODE_W = 3;

   typedef enum logic [SHIFT_MODE_W-1:0] {
      SM_HOLD  = 3'd0,
      SM_SHR   = 3'd1,
      SM_SHL   = 3'd2,
      SM_ROR   = 3'd3,
      SM_ROL   = 3'd4,
      SM_LOAD  = 3'd5,
      SM_CLEAR = 3'd6,
      SM_RSVD  = 3'd7
   } shift_mode_e;

endpackage : gas_util_pkg

// File: rtl/gas_shift_serdes_if.sv
// Bus between gas-engine control logic and the universal shift register:
// operation select, serial inputs, parallel load value and registered outputs.
interface gas_shift_serdes_if
   import gas_util_pkg::*;
#(
   parameter int WIDTH = 8
) ();

   localparam int CNT_W = $clog2(WIDTH);

   shift_mode_e        mode;
   logic               ser_in_r;
   logic               ser_in_l;
   logic [WIDTH-1:0]   load_data;
   logic [WIDTH-1:0]   data;
   logic               ser_out;
   logic [CNT_W-1:0]   shift_cnt;
   logic               frame_done;

   // Controller side: issues operations, observes register state.
   modport master (
      output mode, ser_in_r, ser_in_l, load_data,
      input  data, ser_out, shift_cnt, frame_done
   );

   // Shift register side.
   modport slave (
      input  mode, ser_in_r, ser_in_l, load_data,
      output data, ser_out, shift_cnt, frame_done
   );

endinterface : gas_shift_serdes_if

// File: rtl/shift_frame_counter.sv
// Counts shifts within a WIDTH-bit serial frame and pulses done for one cycle
// after the WIDTH-th shift. restart abandons the current frame silently.
module shift_frame_counter #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             restart,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   // Frame position and end-of-frame pulse; idle cycles pause the count.
   always_ff @(posedge clk) begin
      if (!rst_n || restart) begin
         count <= '0;
         done  <= 1'b0;
      end else if (step) begin
         if (count == LAST) begin
            count <= '0;
            done  <= 1'b1;
         end else begin
            count <= count + 1'b1;
            done  <= 1'b0;
         end
      end else begin
         done  <= 1'b0;
      end
   end

endmodule : shift_frame_counter

// File: rtl/gas_shift_serdes.sv
// Universal shift register for serialising/deserialising gas-engine sensor
// and valve words: shift and rotate in both directions, load, clear, and a
// frame counter flagging each completed WIDTH-bit serial frame.
module gas_shift_serdes
   import gas_util_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   gas_shift_serdes_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH);

   if (WIDTH < 2) begin : g_width_check
      $error("gas_shift_serdes: WIDTH must be at least 2");
   end

   logic [WIDTH-1:0] data_q;
   logic             ser_out_q;
   logic             step;
   logic             restart;
   logic [CNT_W-1:0] cnt;
   logic             done;

   // Classify the requested operation for the frame counter.
   always_comb begin
      step    = 1'b0;
      restart = 1'b0;
      case (bus.mode)
         SM_SHR, SM_SHL, SM_ROR, SM_ROL: step    = 1'b1;
         SM_LOAD, SM_CLEAR:              restart = 1'b1;
         default:                        ;
      endcase
   end

   // Register contents and the last bit pushed out; reset wins over mode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q    <= '0;
         ser_out_q <= 1'b0;
      end else begin
         case (bus.mode)
            SM_SHR: begin
               data_q    <= {bus.ser_in_r, data_q[WIDTH-1:1]};
               ser_out_q <= data_q[0];
            end
            SM_SHL: begin
               data_q    <= {data_q[WIDTH-2:0], bus.ser_in_l};
               ser_out_q <= data_q[WIDTH-1];
            end
            SM_ROR: begin
               data_q    <= {data_q[0], data_q[WIDTH-1:1]};
               ser_out_q <= data_q[0];
            end
            SM_ROL: begin
               data_q    <= {data_q[WIDTH-2:0], data_q[WIDTH-1]};
               ser_out_q <= data_q[WIDTH-1];
            end
            SM_LOAD: begin
               data_q    <= bus.load_data;
            end
            SM_CLEAR: begin
               data_q    <= '0;
               ser_out_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   shift_frame_counter #(
      .WIDTH   (WIDTH)
   ) u_frame_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .step    (step),
      .restart (restart),
      .count   (cnt),
      .done    (done)
   );

   assign bus.data       = data_q;
   assign bus.ser_out    = ser_out_q;
   assign bus.shift_cnt  = cnt;
   assign bus.frame_done = done;

endmodule : gas_shift_serdes
